// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl
// Register-access controller behind an SPI slave. Each SPI transaction carries
// a command byte (bit 7 = read, bits [6:0] = start address) followed by data
// bytes that turn into single-beat, auto-incrementing register bus transfers.
// Overrun/underrun status is reported to the master through the status byte
// {STATUS_ID[7:2], wr_overrun, rd_underrun}.
//
// Ports
//   clk, rst         system clock, synchronous active-high reset
//   spi_data_out     byte received from the master, valid with spi_data_stb
//   spi_data_stb     one-cycle strobe per received byte
//   spi_tsx_start    one-cycle pulse when SSEL asserts
//   spi_data_in      next byte shifted to the master (status or read data)
//   bus_addr         register address (7 bit, wraps 127 -> 0)
//   bus_wdata        write data
//   bus_we, bus_re   write / read request, held until bus_ack
//   bus_rdata        read data, valid in the bus_ack cycle of a read
//   bus_ack          completes the pending request
//   wr_overrun       sticky: data byte arrived while a write was pending
//   rd_underrun      sticky: master clocked a byte while a read was pending
module spi_reg_ctrl #(
    parameter logic [7:0] STATUS_ID = 8'hA4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] spi_data_out,
    input  logic       spi_data_stb,
    input  logic       spi_tsx_start,
    output logic [7:0] spi_data_in,
    output logic [6:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_re,
    input  logic [7:0] bus_rdata,
    input  logic       bus_ack,
    output logic       wr_overrun,
    output logic       rd_underrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    state_t     state_r;
    logic       rd_valid_r;    // read data loaded, next read may be issued
    logic       loaded_r;      // spi_data_in shows read data instead of status
    logic       rd_discard_r;  // pending read belongs to an aborted transaction
    logic       cmd_pend_r;    // command byte latched while a request was pending
    logic [7:0] cmd_byte_r;

    logic       req_s;
    logic       cmd_go_s;
    logic [7:0] cmd_byte_s;
    logic       ovr_set_s;
    logic       und_set_s;
    logic       rd_load_s;
    logic [7:0] status_s;

    // Decode of this cycle's events; the status byte tracks the flags' next value
    // so spi_data_in and the flags change on the same edge.
    always_comb begin
        req_s      = bus_we | bus_re;
        // A newer command byte supersedes one that is still waiting.
        cmd_byte_s = spi_data_stb ? spi_data_out : cmd_byte_r;
        // Commands issue only with the bus idle so address/data stay stable
        // under a held request.
        cmd_go_s   = !spi_tsx_start && (state_r == ST_CMD) && !req_s &&
                     (spi_data_stb || cmd_pend_r);
        ovr_set_s  = !spi_tsx_start && (state_r == ST_WDATA) && spi_data_stb && bus_we;
        und_set_s  = !spi_tsx_start && (state_r == ST_RDATA) && spi_data_stb &&
                     !rd_valid_r && bus_re;
        rd_load_s  = bus_ack && bus_re && !rd_discard_r && !spi_tsx_start;
        status_s   = {STATUS_ID[7:2], wr_overrun | ovr_set_s, rd_underrun | und_set_s};
    end

    // Controller FSM with registered bus, SPI and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            spi_data_in  <= {STATUS_ID[7:2], 2'b00};
            bus_addr     <= 7'd0;
            bus_wdata    <= 8'd0;
            bus_we       <= 1'b0;
            bus_re       <= 1'b0;
            wr_overrun   <= 1'b0;
            rd_underrun  <= 1'b0;
            rd_valid_r   <= 1'b0;
            loaded_r     <= 1'b0;
            rd_discard_r <= 1'b0;
            cmd_pend_r   <= 1'b0;
            cmd_byte_r   <= 8'd0;
        end else begin
            // Bus completion; a write always commits, even after an abort.
            if (bus_ack && bus_we) begin
                bus_we   <= 1'b0;
                bus_addr <= bus_addr + 7'd1;
            end else begin
                bus_we   <= bus_we;
            end
            if (bus_ack && bus_re) begin
                bus_re       <= 1'b0;
                rd_discard_r <= 1'b0;
                if (rd_load_s) begin
                    rd_valid_r <= 1'b1;
                    loaded_r   <= 1'b1;
                end else begin
                    rd_valid_r <= rd_valid_r;
                end
            end else begin
                bus_re <= bus_re;
            end

            if (spi_tsx_start) begin
                // New transaction: the old status byte was sampled this cycle.
                state_r     <= ST_CMD;
                wr_overrun  <= 1'b0;
                rd_underrun <= 1'b0;
                rd_valid_r  <= 1'b0;
                loaded_r    <= 1'b0;
                cmd_pend_r  <= 1'b0;
                spi_data_in <= {STATUS_ID[7:2], 2'b00};
                if (bus_re && !bus_ack) begin
                    rd_discard_r <= 1'b1;
                end else begin
                    rd_discard_r <= rd_discard_r & ~bus_ack;
                end
            end else begin
                if (ovr_set_s) begin
                    wr_overrun <= 1'b1;
                end else begin
                    wr_overrun <= wr_overrun;
                end
                if (und_set_s) begin
                    rd_underrun <= 1'b1;
                end else begin
                    rd_underrun <= rd_underrun;
                end

                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_CMD: begin
                        if (cmd_go_s) begin
                            cmd_pend_r <= 1'b0;
                            bus_addr   <= cmd_byte_s[6:0];
                            if (cmd_byte_s[7]) begin
                                bus_re  <= 1'b1;
                                state_r <= ST_RDATA;
                            end else begin
                                state_r <= ST_WDATA;
                            end
                        end else if (spi_data_stb) begin
                            cmd_pend_r <= 1'b1;
                            cmd_byte_r <= spi_data_out;
                        end else begin
                            cmd_pend_r <= cmd_pend_r;
                        end
                    end
                    ST_WDATA: begin
                        if (spi_data_stb && !bus_we) begin
                            bus_wdata <= spi_data_out;
                            bus_we    <= 1'b1;
                        end else begin
                            bus_wdata <= bus_wdata;
                        end
                    end
                    ST_RDATA: begin
                        // rd_valid implies no request is pending, so the
                        // increment cannot collide with a write-ack increment.
                        if (spi_data_stb && rd_valid_r) begin
                            bus_addr   <= bus_addr + 7'd1;
                            bus_re     <= 1'b1;
                            rd_valid_r <= 1'b0;
                        end else begin
                            state_r <= ST_RDATA;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase

                if (rd_load_s) begin
                    spi_data_in <= bus_rdata;
                end else if (!loaded_r) begin
                    spi_data_in <= status_s;
                end else begin
                    spi_data_in <= spi_data_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

    localparam logic [7:0] SID = 8'hA4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] spi_data_out;
    logic       spi_data_stb;
    logic       spi_tsx_start;
    logic [7:0] spi_data_in;
    logic [6:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata;
    logic       bus_ack;
    logic       wr_overrun;
    logic       rd_underrun;

    int checks = 0;
    int failures = 0;

    spi_reg_ctrl #(.STATUS_ID(SID)) dut (
        .clk(clk), .rst(rst),
        .spi_data_out(spi_data_out), .spi_data_stb(spi_data_stb),
        .spi_tsx_start(spi_tsx_start), .spi_data_in(spi_data_in),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .wr_overrun(wr_overrun), .rd_underrun(rd_underrun)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- bus slave ----------------
    int  lat_fixed = 0;     // -1: random latency per request
    bit  rd_from_addr = 1'b1;
    int  age = 0;
    int  cur_lat = 0;

    always @(posedge clk) begin
        #1;
        if (rst || !(bus_we || bus_re)) begin
            bus_ack = 1'b0;
            age = 0;
        end else begin
            if (age == 0) begin
                if (lat_fixed >= 0) cur_lat = lat_fixed;
                else if ($urandom_range(0, 7) == 0) cur_lat = 9;
                else cur_lat = $urandom_range(0, 3);
            end
            bus_ack = (age >= cur_lat);
            bus_rdata = rd_from_addr ? (8'({1'b0, bus_addr}) + 8'h40) : 8'($urandom);
            age++;
        end
    end

    // ---------------- behavioural reference model ----------------
    // Transaction view: phase of the SPI transaction, the one outstanding bus
    // request, what the master will see next, and the sticky flags.
    typedef enum int {M_IDLE, M_CMD, M_WR, M_RD} mphase_t;
    mphase_t    m_phase;
    logic [6:0] m_addr;
    logic [7:0] m_wdata;
    int         m_req;        // 0 none, 1 write, 2 read
    bit         m_stale;      // outstanding read belongs to an aborted transaction
    bit         m_ready;      // read byte delivered, next byte may fetch
    bit         m_loaded;
    logic [7:0] m_shown;
    bit         m_ovr, m_und;
    bit         m_cmd_wait;
    logic [7:0] m_cmd;
    bit         m_valid = 1'b0;

    task automatic model_edge();
        int req0;
        bit ready0;
        logic [7:0] c;
        if (rst) begin
            m_phase = M_IDLE; m_addr = 7'd0; m_wdata = 8'd0; m_req = 0;
            m_stale = 0; m_ready = 0; m_loaded = 0; m_shown = 8'd0;
            m_ovr = 0; m_und = 0; m_cmd_wait = 0; m_cmd = 8'd0;
            m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        req0 = m_req;
        ready0 = m_ready;
        if (bus_ack && m_req != 0) begin
            if (m_req == 1) m_addr = m_addr + 7'd1;
            else if (!m_stale && !spi_tsx_start) begin
                m_shown = bus_rdata; m_loaded = 1; m_ready = 1;
            end
            m_req = 0;
            m_stale = 0;
        end
        if (spi_tsx_start) begin
            if (req0 == 2 && !bus_ack) m_stale = 1;
            m_phase = M_CMD; m_ovr = 0; m_und = 0;
            m_ready = 0; m_loaded = 0; m_cmd_wait = 0;
            return;
        end
        if (m_phase == M_CMD) begin
            if (req0 != 0) begin
                if (spi_data_stb) begin m_cmd_wait = 1; m_cmd = spi_data_out; end
            end else if (spi_data_stb || m_cmd_wait) begin
                c = spi_data_stb ? spi_data_out : m_cmd;
                m_cmd_wait = 0;
                m_addr = c[6:0];
                if (c[7]) begin m_req = 2; m_phase = M_RD; end
                else m_phase = M_WR;
            end
        end else if (m_phase == M_WR && spi_data_stb) begin
            if (req0 == 1) m_ovr = 1;
            else begin m_wdata = spi_data_out; m_req = 1; end
        end else if (m_phase == M_RD && spi_data_stb) begin
            if (ready0) begin m_addr = m_addr + 7'd1; m_req = 2; m_ready = 0; end
            else if (req0 == 2) m_und = 1;
        end
    endtask

    always @(posedge clk) model_edge();

    // Compare every cycle once reset has been applied.
    always @(negedge clk) begin
        if (m_valid) begin
            cmp("spi_data_in", 32'(spi_data_in),
                32'(m_loaded ? m_shown : {SID[7:2], m_ovr, m_und}));
            cmp("bus_we", 32'(bus_we), 32'(m_req == 1));
            cmp("bus_re", 32'(bus_re), 32'(m_req == 2));
            cmp("bus_addr", 32'(bus_addr), 32'(m_addr));
            cmp("bus_wdata", 32'(bus_wdata), 32'(m_wdata));
            cmp("wr_overrun", 32'(wr_overrun), 32'(m_ovr));
            cmp("rd_underrun", 32'(rd_underrun), 32'(m_und));
        end
    end

    // ---------------- transfer monitor for literal checks ----------------
    logic [14:0] wlog[$];
    logic [6:0]  rlog[$];
    logic [7:0]  shown_q[$];
    bit          rd_ack_prev = 1'b0;

    always @(negedge clk) begin
        if (rd_ack_prev) shown_q.push_back(spi_data_in);
        rd_ack_prev = bus_ack && bus_re;
        if (bus_ack && bus_we) wlog.push_back({bus_addr, bus_wdata});
        if (bus_ack && bus_re) rlog.push_back(bus_addr);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        spi_data_out = b;
        spi_data_stb = 1'b1;
        tick();
        spi_data_stb = 1'b0;
    endtask

    task automatic start();
        spi_tsx_start = 1'b1;
        tick();
        spi_tsx_start = 1'b0;
    endtask

    task automatic clear_logs();
        wlog.delete();
        rlog.delete();
        shown_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cmd;
        int nb;
        rst = 1'b1; spi_data_out = 8'd0; spi_data_stb = 1'b0;
        spi_tsx_start = 1'b0; bus_rdata = 8'd0; bus_ack = 1'b0;
        idle(3);
        rst = 1'b0;

        // Reset values.
        cmp("rst_spi_data_in", 32'(spi_data_in), 32'h0A4);
        cmp("rst_bus_addr", 32'(bus_addr), 32'h0);
        cmp("rst_req", 32'({bus_we, bus_re}), 32'h0);
        cmp("rst_flags", 32'({wr_overrun, rd_underrun}), 32'h0);

        // Write burst, ack in the first request cycle.
        lat_fixed = 0; rd_from_addr = 1'b1;
        clear_logs();
        start();
        send_byte(8'h05); idle(2);
        send_byte(8'h11); idle(2);
        send_byte(8'h22); idle(4);
        cmp("wburst_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            cmp("wburst_w0", 32'(wlog[0]), 32'({7'h05, 8'h11}));
            cmp("wburst_w1", 32'(wlog[1]), 32'({7'h06, 8'h22}));
        end
        cmp("wburst_sdi", 32'(spi_data_in), 32'h0A4);
        cmp("wburst_flags", 32'({wr_overrun, rd_underrun}), 32'h0);

        // Read burst from 0x7E with wrap; bus returns addr + 0x40.
        clear_logs();
        start();
        send_byte(8'hFE); idle(4);
        send_byte(8'h00); idle(4);
        send_byte(8'h00); idle(6);
        cmp("rburst_count", 32'(rlog.size()), 32'd3);
        cmp("rburst_shown_count", 32'(shown_q.size()), 32'd3);
        if (rlog.size() == 3 && shown_q.size() == 3) begin
            cmp("rburst_a0", 32'(rlog[0]), 32'h7E);
            cmp("rburst_a1", 32'(rlog[1]), 32'h7F);
            cmp("rburst_a2", 32'(rlog[2]), 32'h00);
            cmp("rburst_d0", 32'(shown_q[0]), 32'hBE);
            cmp("rburst_d1", 32'(shown_q[1]), 32'hBF);
            cmp("rburst_d2", 32'(shown_q[2]), 32'h40);
        end

        // Write overrun: ack held 20 clk, second byte 5 clk after the first.
        lat_fixed = 20;
        clear_logs();
        start();
        send_byte(8'h10); idle(1);
        send_byte(8'h33); idle(4);
        send_byte(8'h44); idle(25);
        cmp("ovr_flag", 32'(wr_overrun), 32'd1);
        cmp("ovr_count", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) cmp("ovr_w0", 32'(wlog[0]), 32'({7'h10, 8'h33}));
        spi_tsx_start = 1'b1;
        cmp("ovr_status_sampled", 32'(spi_data_in), 32'h0A6);
        tick();
        spi_tsx_start = 1'b0;
        cmp("ovr_cleared", 32'(wr_overrun), 32'd0);
        cmp("ovr_sdi_after", 32'(spi_data_in), 32'h0A4);

        // Read underrun: ack held past the next strobe.
        lat_fixed = 8;
        clear_logs();
        start();
        send_byte(8'h85); idle(2);
        send_byte(8'h00); idle(15);
        cmp("und_flag", 32'(rd_underrun), 32'd1);
        cmp("und_count", 32'(rlog.size()), 32'd1);
        cmp("und_late_data", 32'(spi_data_in), 32'h45);

        // Abort during a pending read, then a deferred write command.
        lat_fixed = 6;
        clear_logs();
        start();
        send_byte(8'h90); idle(1);
        start();
        send_byte(8'h03); idle(10);
        cmp("abort_sdi", 32'(spi_data_in), 32'h0A4);
        cmp("abort_reads", 32'(rlog.size()), 32'd1);
        send_byte(8'h77); idle(12);
        cmp("abort_wcount", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) cmp("abort_w0", 32'(wlog[0]), 32'({7'h03, 8'h77}));

        // Reset with a write pending.
        lat_fixed = 20;
        start();
        send_byte(8'h20);
        send_byte(8'h55); idle(2);
        cmp("rst_we_before", 32'(bus_we), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        cmp("rst2_we", 32'(bus_we), 32'd0);
        cmp("rst2_addr", 32'(bus_addr), 32'd0);
        cmp("rst2_wdata", 32'(bus_wdata), 32'd0);
        cmp("rst2_sdi", 32'(spi_data_in), 32'h0A4);
        send_byte(8'h81); idle(3);
        cmp("rst2_idle_req", 32'({bus_we, bus_re}), 32'd0);

        // Randomised transactions against the model.
        lat_fixed = -1; rd_from_addr = 1'b0;
        for (int t = 0; t < 200; t++) begin
            start();
            idle($urandom_range(0, 2));
            cmd = 8'($urandom);
            if ($urandom_range(0, 3) == 0) cmd[6:0] = 7'(7'h7C + 7'($urandom_range(0, 3)));
            send_byte(cmd);
            nb = $urandom_range(0, 5);
            for (int b = 0; b < nb; b++) begin
                idle($urandom_range(0, 6));
                send_byte(8'($urandom));
            end
            idle($urandom_range(0, 8));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end
        end
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
